// File: rtl/rib_arbiter2.sv
// Two-master, one-slave RIB arbiter (m0 = ibus, m1 = dbus), one transaction in flight.
// Define RIB_ARB_RR_EN for round-robin tie-breaking; otherwise m1 has fixed priority.
module rib_arbiter2 #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rstn,

    input  logic [ADDR_W-1:0]   i_ribm_addr0,
    input  logic                i_ribm_wrcs0,
    input  logic [DATA_W/8-1:0] i_ribm_mask0,
    input  logic [DATA_W-1:0]   i_ribm_wdata0,
    input  logic                i_ribm_req0,
    output logic                o_ribm_gnt0,
    output logic                o_ribm_rsp0,
    output logic [DATA_W-1:0]   o_ribm_rdata0,
    input  logic                i_ribm_rdy0,

    input  logic [ADDR_W-1:0]   i_ribm_addr1,
    input  logic                i_ribm_wrcs1,
    input  logic [DATA_W/8-1:0] i_ribm_mask1,
    input  logic [DATA_W-1:0]   i_ribm_wdata1,
    input  logic                i_ribm_req1,
    output logic                o_ribm_gnt1,
    output logic                o_ribm_rsp1,
    output logic [DATA_W-1:0]   o_ribm_rdata1,
    input  logic                i_ribm_rdy1,

    output logic [ADDR_W-1:0]   o_ribs_addr,
    output logic                o_ribs_wrcs,
    output logic [DATA_W/8-1:0] o_ribs_mask,
    output logic [DATA_W-1:0]   o_ribs_wdata,
    output logic                o_ribs_req,
    input  logic                i_ribs_gnt,
    input  logic                i_ribs_rsp,
    input  logic [DATA_W-1:0]   i_ribs_rdata,
    output logic                o_ribs_rdy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t r_state;
    logic   r_own;
`ifdef RIB_ARB_RR_EN
    logic   r_ptr;
`endif

    logic                w_any_req;
    logic                w_win;
    logic                w_sel;
    logic                w_own_req;
    logic                w_own_rdy;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_wrcs;
    logic [DATA_W/8-1:0] w_mask;
    logic [DATA_W-1:0]   w_wdata;

    assign w_any_req = i_ribm_req0 | i_ribm_req1;
    assign w_own_req = r_own ? i_ribm_req1 : i_ribm_req0;
    assign w_own_rdy = r_own ? i_ribm_rdy1 : i_ribm_rdy0;

    // r_ptr holds the last granted master; on a tie the other one wins
    always_comb begin
        w_win = i_ribm_req1;
`ifdef RIB_ARB_RR_EN
        if (i_ribm_req0 && i_ribm_req1)
            w_win = ~r_ptr;
`endif
    end

    assign w_sel   = (r_state == S_IDLE) ? w_win : r_own;
    assign w_addr  = w_sel ? i_ribm_addr1  : i_ribm_addr0;
    assign w_wrcs  = w_sel ? i_ribm_wrcs1  : i_ribm_wrcs0;
    assign w_mask  = w_sel ? i_ribm_mask1  : i_ribm_mask0;
    assign w_wdata = w_sel ? i_ribm_wdata1 : i_ribm_wdata0;

    // Outputs are gated by i_rstn so everything reads 0 during reset
    always_comb begin
        o_ribs_addr   = '0;
        o_ribs_wrcs   = 1'b0;
        o_ribs_mask   = '0;
        o_ribs_wdata  = '0;
        o_ribs_req    = 1'b0;
        o_ribs_rdy    = 1'b0;
        o_ribm_gnt0   = 1'b0;
        o_ribm_gnt1   = 1'b0;
        o_ribm_rsp0   = 1'b0;
        o_ribm_rsp1   = 1'b0;
        o_ribm_rdata0 = '0;
        o_ribm_rdata1 = '0;
        if (i_rstn) begin
            case (r_state)
                S_IDLE, S_REQ: begin
                    if ((r_state == S_IDLE) ? w_any_req : w_own_req) begin
                        o_ribs_addr  = w_addr;
                        o_ribs_wrcs  = w_wrcs;
                        o_ribs_mask  = w_mask;
                        o_ribs_wdata = w_wdata;
                        o_ribs_req   = 1'b1;
                        o_ribm_gnt0  = i_ribs_gnt & ~w_sel;
                        o_ribm_gnt1  = i_ribs_gnt &  w_sel;
                    end
                end
                S_RSP: begin
                    o_ribs_rdy = w_own_rdy;
                    if (r_own) begin
                        o_ribm_rsp1   = i_ribs_rsp;
                        o_ribm_rdata1 = i_ribs_rdata;
                    end else begin
                        o_ribm_rsp0   = i_ribs_rsp;
                        o_ribm_rdata0 = i_ribs_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_own   <= 1'b0;
`ifdef RIB_ARB_RR_EN
            r_ptr   <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_own <= w_win;
                        if (i_ribs_gnt) begin
                            r_state <= S_RSP;
`ifdef RIB_ARB_RR_EN
                            r_ptr   <= w_win;
`endif
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (!w_own_req) begin
                        r_state <= S_IDLE;
                    end else if (i_ribs_gnt) begin
                        r_state <= S_RSP;
`ifdef RIB_ARB_RR_EN
                        r_ptr   <= r_own;
`endif
                    end
                end
                S_RSP: begin
                    if (i_ribs_rsp && w_own_rdy)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_arbiter2.sv
// Scoreboard bench for rib_arbiter2: expected grants/responses are queued as stimulus is
// driven and popped by a negedge monitor; honours RIB_ARB_RR_EN for tie expectations.
module tb_rib_arbiter2;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h2000_0000;
    localparam logic [31:0] WD1 = 32'h1234_5678;
`ifdef RIB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [31:0] i_ribm_addr0, i_ribm_wdata0, i_ribm_addr1, i_ribm_wdata1;
    logic        i_ribm_wrcs0, i_ribm_req0, i_ribm_rdy0;
    logic        i_ribm_wrcs1, i_ribm_req1, i_ribm_rdy1;
    logic [3:0]  i_ribm_mask0, i_ribm_mask1;
    logic        o_ribm_gnt0, o_ribm_rsp0, o_ribm_gnt1, o_ribm_rsp1;
    logic [31:0] o_ribm_rdata0, o_ribm_rdata1;
    logic [31:0] o_ribs_addr, o_ribs_wdata, i_ribs_rdata;
    logic        o_ribs_wrcs, o_ribs_req, o_ribs_rdy;
    logic [3:0]  o_ribs_mask;
    logic        i_ribs_gnt, i_ribs_rsp;

    always #5 i_clk = ~i_clk;

    rib_arbiter2 #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_ribm_addr0(i_ribm_addr0), .i_ribm_wrcs0(i_ribm_wrcs0), .i_ribm_mask0(i_ribm_mask0),
        .i_ribm_wdata0(i_ribm_wdata0), .i_ribm_req0(i_ribm_req0), .o_ribm_gnt0(o_ribm_gnt0),
        .o_ribm_rsp0(o_ribm_rsp0), .o_ribm_rdata0(o_ribm_rdata0), .i_ribm_rdy0(i_ribm_rdy0),
        .i_ribm_addr1(i_ribm_addr1), .i_ribm_wrcs1(i_ribm_wrcs1), .i_ribm_mask1(i_ribm_mask1),
        .i_ribm_wdata1(i_ribm_wdata1), .i_ribm_req1(i_ribm_req1), .o_ribm_gnt1(o_ribm_gnt1),
        .o_ribm_rsp1(o_ribm_rsp1), .o_ribm_rdata1(o_ribm_rdata1), .i_ribm_rdy1(i_ribm_rdy1),
        .o_ribs_addr(o_ribs_addr), .o_ribs_wrcs(o_ribs_wrcs), .o_ribs_mask(o_ribs_mask),
        .o_ribs_wdata(o_ribs_wdata), .o_ribs_req(o_ribs_req), .i_ribs_gnt(i_ribs_gnt),
        .i_ribs_rsp(i_ribs_rsp), .i_ribs_rdata(i_ribs_rdata), .o_ribs_rdy(o_ribs_rdy)
    );

    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic        wrcs;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } gnt_t;
    typedef struct {
        logic        m;
        logic [31:0] data;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic gnt_t mk_gnt(input logic m);
        gnt_t g;
        g.m     = m;
        g.addr  = m ? A1 : A0;
        g.wrcs  = m;
        g.mask  = m ? 4'hF : 4'h0;
        g.wdata = m ? WD1 : 32'h0;
        return g;
    endfunction

    function automatic rsp_t mk_rsp(input logic m, input logic [31:0] d);
        rsp_t r;
        r.m    = m;
        r.data = d;
        return r;
    endfunction

    // Monitor: every observed grant / completed response must match the queue head
    always @(negedge i_clk) begin
        if (o_ribm_gnt0 || o_ribm_gnt1) begin
            if (gnt_q.size() == 0) begin
                chk("gnt_unexpected", 64'({o_ribm_gnt1, o_ribm_gnt0}), 64'd0);
            end else begin
                gnt_t g;
                g = gnt_q.pop_front();
                chk("gnt_who",   64'({o_ribm_gnt1, o_ribm_gnt0}), g.m ? 64'd2 : 64'd1);
                chk("gnt_addr",  64'(o_ribs_addr),  64'(g.addr));
                chk("gnt_wrcs",  64'(o_ribs_wrcs),  64'(g.wrcs));
                chk("gnt_mask",  64'(o_ribs_mask),  64'(g.mask));
                chk("gnt_wdata", 64'(o_ribs_wdata), 64'(g.wdata));
            end
        end
        if ((o_ribm_rsp0 && i_ribm_rdy0) || (o_ribm_rsp1 && i_ribm_rdy1)) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 64'({o_ribm_rsp1, o_ribm_rsp0}), 64'd0);
            end else begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rsp_who",   64'({o_ribm_rsp1, o_ribm_rsp0}), r.m ? 64'd2 : 64'd1);
                chk("rsp_data",  64'(r.m ? o_ribm_rdata1 : o_ribm_rdata0), 64'(r.data));
                chk("rsp_other", 64'(r.m ? o_ribm_rdata0 : o_ribm_rdata1), 64'd0);
                chk("rsp_rdy",   64'(o_ribs_rdy), 64'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mdrv(input logic m, input logic req);
        gnt_t g;
        g = mk_gnt(m);
        if (m) begin
            i_ribm_req1 = req; i_ribm_addr1 = req ? g.addr : '0; i_ribm_wrcs1 = req & g.wrcs;
            i_ribm_mask1 = req ? g.mask : '0; i_ribm_wdata1 = req ? g.wdata : '0;
        end else begin
            i_ribm_req0 = req; i_ribm_addr0 = req ? g.addr : '0; i_ribm_wrcs0 = req & g.wrcs;
            i_ribm_mask0 = req ? g.mask : '0; i_ribm_wdata0 = req ? g.wdata : '0;
        end
    endtask

    task automatic clear_inputs();
        mdrv(1'b0, 1'b0);
        mdrv(1'b1, 1'b0);
        i_ribm_rdy0 = 1'b1; i_ribm_rdy1 = 1'b1;
        i_ribs_gnt = 1'b0; i_ribs_rsp = 1'b0; i_ribs_rdata = '0;
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        clear_inputs();
        mdrv(1'b0, 1'b1);
        i_ribs_gnt = 1'b1;
        #2;
        chk("rst_req", 64'(o_ribs_req), 64'd0);
        chk("rst_gnt", 64'({o_ribm_gnt1, o_ribm_gnt0}), 64'd0);
        chk("rst_addr", 64'(o_ribs_addr), 64'd0);
        cyc();
        clear_inputs();
        #2;
        i_rstn = 1'b1;
        #1;
        chk("idle_req", 64'(o_ribs_req), 64'd0);
        chk("idle_fields", 64'({o_ribs_addr, o_ribs_mask, o_ribs_wrcs}), 64'd0);
    endtask

    task automatic do_txn(input logic m, input logic [31:0] rd);
        cyc();
        mdrv(m, 1'b1);
        i_ribs_gnt = 1'b1;
        gnt_q.push_back(mk_gnt(m));
        #2;
        chk("txn_gnt", 64'(m ? o_ribm_gnt1 : o_ribm_gnt0), 64'd1);
        chk("txn_gnt_other", 64'(m ? o_ribm_gnt0 : o_ribm_gnt1), 64'd0);
        cyc();
        mdrv(m, 1'b0);
        i_ribs_gnt = 1'b0; i_ribs_rsp = 1'b1; i_ribs_rdata = rd;
        rsp_q.push_back(mk_rsp(m, rd));
        #2;
        chk("txn_rsp", 64'(m ? o_ribm_rsp1 : o_ribm_rsp0), 64'd1);
        chk("txn_rsp_other", 64'(m ? o_ribm_rsp0 : o_ribm_rsp1), 64'd0);
        chk("txn_rsp_noreq", 64'(o_ribs_req), 64'd0);
        cyc();
        i_ribs_rsp = 1'b0; i_ribs_rdata = '0;
    endtask

    task automatic tie_test(input logic first, input logic [31:0] rd_a, input logic [31:0] rd_b);
        cyc();
        mdrv(1'b0, 1'b1);
        mdrv(1'b1, 1'b1);
        i_ribs_gnt = 1'b1;
        gnt_q.push_back(mk_gnt(first));
        #2;
        chk("tie_first", 64'({o_ribm_gnt1, o_ribm_gnt0}), first ? 64'd2 : 64'd1);
        cyc();
        mdrv(first, 1'b0);
        i_ribs_rsp = 1'b1; i_ribs_rdata = rd_a;
        rsp_q.push_back(mk_rsp(first, rd_a));
        #2;
        chk("tie_no_gnt_rsp", 64'({o_ribm_gnt1, o_ribm_gnt0}), 64'd0);
        chk("tie_no_req_rsp", 64'(o_ribs_req), 64'd0);
        cyc();
        i_ribs_rsp = 1'b0; i_ribs_rdata = '0;
        gnt_q.push_back(mk_gnt(~first));
        #2;
        chk("tie_second", 64'({o_ribm_gnt1, o_ribm_gnt0}), first ? 64'd1 : 64'd2);
        cyc();
        mdrv(~first, 1'b0);
        i_ribs_gnt = 1'b0; i_ribs_rsp = 1'b1; i_ribs_rdata = rd_b;
        rsp_q.push_back(mk_rsp(~first, rd_b));
        cyc();
        i_ribs_rsp = 1'b0; i_ribs_rdata = '0;
    endtask

    initial begin
        i_rstn = 1'b0;
        clear_inputs();
        #3;

        // Single read from m0
        do_reset();
        do_txn(1'b0, 32'hDEAD_BEEF);
        chk("m1_idle", 64'({o_ribm_gnt1, o_ribm_rsp1, o_ribm_rdata1}), 64'd0);

        // Simultaneous requests; second and third ties exercise the pointer
        do_reset();
        tie_test(RR ? 1'b0 : 1'b1, 32'h0000_00A5, 32'h0000_005A);
        tie_test(RR ? 1'b0 : 1'b1, 32'h1111_1111, 32'h2222_2222);
        do_txn(1'b0, 32'h3333_3333);
        tie_test(1'b1, 32'h4444_4444, 32'h5555_5555);

        // Slave gnt low for 3 cycles; m1 arrives late and must wait
        do_reset();
        cyc();
        mdrv(1'b0, 1'b1);
        #2;
        chk("stall_req", 64'(o_ribs_req), 64'd1);
        chk("stall_gnt0", 64'(o_ribm_gnt0), 64'd0);
        for (int i = 1; i < 3; i++) begin
            cyc();
            mdrv(1'b1, 1'b1);
            #2;
            chk("stall_hold_addr", 64'(o_ribs_addr), 64'(A0));
            chk("stall_no_gnt", 64'({o_ribm_gnt1, o_ribm_gnt0}), 64'd0);
        end
        cyc();
        i_ribs_gnt = 1'b1;
        gnt_q.push_back(mk_gnt(1'b0));
        #2;
        chk("stall_gnt_c3", 64'({o_ribm_gnt1, o_ribm_gnt0}), 64'd1);
        cyc();
        mdrv(1'b0, 1'b0);
        i_ribs_gnt = 1'b0; i_ribs_rsp = 1'b1; i_ribs_rdata = 32'hCAFE_0000;
        rsp_q.push_back(mk_rsp(1'b0, 32'hCAFE_0000));
        cyc();
        i_ribs_rsp = 1'b0; i_ribs_rdata = '0; i_ribs_gnt = 1'b1;
        gnt_q.push_back(mk_gnt(1'b1));
        #2;
        chk("stall_m1_gnt", 64'(o_ribm_gnt1), 64'd1);
        cyc();
        mdrv(1'b1, 1'b0);
        i_ribs_gnt = 1'b0; i_ribs_rsp = 1'b1; i_ribs_rdata = 32'hCAFE_0001;
        rsp_q.push_back(mk_rsp(1'b1, 32'hCAFE_0001));
        cyc();
        i_ribs_rsp = 1'b0; i_ribs_rdata = '0;

        // Response backpressure on m1
        do_reset();
        cyc();
        mdrv(1'b1, 1'b1);
        i_ribs_gnt = 1'b1;
        gnt_q.push_back(mk_gnt(1'b1));
        cyc();
        mdrv(1'b1, 1'b0);
        i_ribs_gnt = 1'b0; i_ribs_rsp = 1'b1; i_ribs_rdata = 32'hBEEF_0001;
        i_ribm_rdy1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("bp_rdy", 64'(o_ribs_rdy), 64'd0);
            chk("bp_rsp1", 64'(o_ribm_rsp1), 64'd1);
            cyc();
            mdrv(1'b0, 1'b1);
            i_ribs_gnt = 1'b1;
            #2;
            chk("bp_hold_rsp", 64'({o_ribs_req, o_ribm_gnt0}), 64'd0);
            i_ribs_gnt = 1'b0;
        end
        i_ribm_rdy1 = 1'b1;
        rsp_q.push_back(mk_rsp(1'b1, 32'hBEEF_0001));
        #1;
        chk("bp_done_rdy", 64'(o_ribs_rdy), 64'd1);
        cyc();
        i_ribs_rsp = 1'b0; i_ribs_rdata = '0; i_ribs_gnt = 1'b1;
        gnt_q.push_back(mk_gnt(1'b0));
        #2;
        chk("bp_idle_gnt0", 64'(o_ribm_gnt0), 64'd1);
        cyc();
        mdrv(1'b0, 1'b0);
        i_ribs_gnt = 1'b0; i_ribs_rsp = 1'b1; i_ribs_rdata = 32'h0BAD_F00D;
        rsp_q.push_back(mk_rsp(1'b0, 32'h0BAD_F00D));
        cyc();
        i_ribs_rsp = 1'b0; i_ribs_rdata = '0;

        // Stray responses in IDLE and REQ are dropped
        do_reset();
        cyc();
        i_ribs_rsp = 1'b1; i_ribs_rdata = 32'hFFFF_FFFF;
        #2;
        chk("stray_idle_rsp", 64'({o_ribm_rsp1, o_ribm_rsp0, o_ribs_rdy}), 64'd0);
        chk("stray_idle_rdata", 64'(o_ribm_rdata0 | o_ribm_rdata1), 64'd0);
        cyc();
        mdrv(1'b0, 1'b1);
        cyc();
        #2;
        chk("stray_req_rsp", 64'({o_ribm_rsp1, o_ribm_rsp0, o_ribs_rdy}), 64'd0);
        cyc();
        mdrv(1'b0, 1'b0);
        i_ribs_rsp = 1'b0; i_ribs_rdata = '0;
        cyc();
        #2;
        chk("drop_req_idle", 64'(o_ribs_req), 64'd0);

        // Reset in RSP aborts the transaction
        do_reset();
        cyc();
        mdrv(1'b0, 1'b1);
        i_ribs_gnt = 1'b1;
        gnt_q.push_back(mk_gnt(1'b0));
        cyc();
        mdrv(1'b0, 1'b0);
        i_ribs_gnt = 1'b0; i_ribs_rsp = 1'b1; i_ribs_rdata = 32'h7777_7777; i_ribm_rdy0 = 1'b0;
        #2;
        chk("rstrsp_pre", 64'(o_ribm_rsp0), 64'd1);
        i_rstn = 1'b0;
        #1;
        chk("rstrsp_rsp", 64'({o_ribm_rsp1, o_ribm_rsp0, o_ribs_rdy}), 64'd0);
        chk("rstrsp_rdata", 64'(o_ribm_rdata0), 64'd0);
        cyc();
        clear_inputs();
        #2;
        i_rstn = 1'b1;
        #1;
        chk("rstrsp_after", 64'({o_ribm_rsp0, o_ribs_req}), 64'd0);
        do_txn(1'b0, 32'h8888_8888);

        cyc();
        cyc();
        chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
